// File: rtl/usb3_tp_tx_arbiter_pkg.sv
// Shared constants and types for the USB3 transaction-packet transmit arbiter:
// LTSSM encodings, TP field widths, arbiter state encoding and the TP field bundle.
package usb3_tp_tx_arbiter_pkg;

    // LTSSM state encodings seen by the arbiter (5-bit link state).
    localparam int         LTSSM_W     = 5;
    localparam logic [4:0] LT_U0       = 5'd16;
    localparam logic [4:0] LT_RECOVERY = 5'd20;

    // TP field widths.
    localparam int SUBTYPE_W = 4;
    localparam int ENDP_W    = 4;
    localparam int NUMP_W    = 5;
    localparam int SEQ_W     = 5;
    localparam int STREAM_W  = 16;

    // Width of the optional ISSUE-timeout counter.
    localparam int TO_CNT_W  = 10;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    // One requester's complete TP description, latched as a unit at grant.
    typedef struct packed {
        logic                 retry;
        logic                 dir;
        logic [SUBTYPE_W-1:0] subtype;
        logic [ENDP_W-1:0]    endp;
        logic [NUMP_W-1:0]    nump;
        logic [SEQ_W-1:0]     seq;
        logic [STREAM_W-1:0]  stream;
    } tp_fields_t;

endpackage

// File: rtl/usb3_tp_tx_arbiter_if.sv
// Bundle between the protocol-layer requesters / link TP slot and the arbiter.
// master: requester and link side (drives requests, link state and tp_ack).
// slave : the arbiter itself.
interface usb3_tp_tx_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import usb3_tp_tx_arbiter_pkg::*;

    // Link state
    logic [LTSSM_W-1:0]             ltssm_state;

    // Requester side, packed per requester
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             req_retry;
    logic [NUM_REQ-1:0]             req_dir;
    logic [SUBTYPE_W*NUM_REQ-1:0]   req_subtype;
    logic [ENDP_W*NUM_REQ-1:0]      req_endp;
    logic [NUMP_W*NUM_REQ-1:0]      req_nump;
    logic [SEQ_W*NUM_REQ-1:0]       req_seq;
    logic [STREAM_W*NUM_REQ-1:0]    req_stream;
    logic [NUM_REQ-1:0]             done;
    logic [NUM_REQ-1:0]             err;

    // Link TP slot
    logic                           tp;
    logic                           tp_retry;
    logic                           tp_dir;
    logic [SUBTYPE_W-1:0]           tp_subtype;
    logic [ENDP_W-1:0]              tp_endp;
    logic [NUMP_W-1:0]              tp_nump;
    logic [SEQ_W-1:0]               tp_seq;
    logic [STREAM_W-1:0]            tp_stream;
    logic                           tp_ack;

    logic                           busy;

    modport master (
        output ltssm_state, req, req_retry, req_dir, req_subtype, req_endp,
               req_nump, req_seq, req_stream, tp_ack,
        input  done, err, tp, tp_retry, tp_dir, tp_subtype, tp_endp,
               tp_nump, tp_seq, tp_stream, busy
    );

    modport slave (
        input  ltssm_state, req, req_retry, req_dir, req_subtype, req_endp,
               req_nump, req_seq, req_stream, tp_ack,
        output done, err, tp, tp_retry, tp_dir, tp_subtype, tp_endp,
               tp_nump, tp_seq, tp_stream, busy
    );

endinterface

// File: rtl/usb3_tp_tx_arbiter_rr_pick.sv
// usb3_rr_pick: combinational round-robin picker. Returns the first set request
// at or after i_rr_ptr, wrapping modulo NUM_REQ. Shared with other arbiters.
module usb3_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_valid
);

    int               w_idx;
    logic [PTR_W-1:0] w_cand;

    // Scan from the farthest candidate back to rr_ptr so the nearest set request wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        o_winner = i_rr_ptr;
        o_valid  = 1'b0;
        w_idx    = 0;
        w_cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = PTR_W'(w_idx);
            if (i_req[w_cand]) begin
                o_winner = w_cand;
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb3_tp_tx_arbiter.sv
// usb3_tp_tx_arbiter: shares one link-layer TP transmit slot among NUM_REQ
// protocol-layer requesters with round-robin grants. A granted TP is held until
// tp_ack; link loss (or, with USB3_TP_ARB_TIMEOUT_EN, an ack timeout) aborts it
// with an err pulse to the owner. Optional feature macro: USB3_TP_ARB_TIMEOUT_EN.
module usb3_tp_tx_arbiter
    import usb3_tp_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    usb3_tp_tx_arbiter_if.slave        bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t        r_state;
    logic              r_tp;
    logic [PTR_W-1:0]  r_winner;
    logic [PTR_W-1:0]  r_rr_ptr;
    tp_fields_t        r_fields;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;

    logic              w_link_up;
    logic              w_valid;
    logic [PTR_W-1:0]  w_winner;
    logic              w_timeout;
    tp_fields_t        w_req_fields [NUM_REQ];
    tp_fields_t        w_sel_fields;

    assign w_link_up = (bus.ltssm_state == LT_U0);

    usb3_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Unpack the per-requester field slices and select the candidate winner's set.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_fields[i].retry   = bus.req_retry[i];
            w_req_fields[i].dir     = bus.req_dir[i];
            w_req_fields[i].subtype = bus.req_subtype[SUBTYPE_W*i +: SUBTYPE_W];
            w_req_fields[i].endp    = bus.req_endp[ENDP_W*i +: ENDP_W];
            w_req_fields[i].nump    = bus.req_nump[NUMP_W*i +: NUMP_W];
            w_req_fields[i].seq     = bus.req_seq[SEQ_W*i +: SEQ_W];
            w_req_fields[i].stream  = bus.req_stream[STREAM_W*i +: STREAM_W];
        end
        w_sel_fields = w_req_fields[w_winner];
    end

    // Pointer to the requester after idx, wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

`ifdef USB3_TP_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_to_cnt;
    assign w_timeout = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYC));
`else
    // ISSUE waits indefinitely for tp_ack or link loss; TIMEOUT_CYC has no effect.
    assign w_timeout = 1'b0 && (TIMEOUT_CYC != 0);
`endif

    // Arbiter FSM: grant in IDLE, hold the TP in ISSUE until ack, link loss or timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ARB_IDLE;
            r_tp     <= 1'b0;
            r_winner <= '0;
            r_rr_ptr <= '0;
            r_fields <= '0;
            r_done   <= '0;
            r_err    <= '0;
`ifdef USB3_TP_ARB_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here; the later per-bit pulse writes override these defaults.
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_link_up && w_valid) begin
                        r_state  <= ARB_ISSUE;
                        r_tp     <= 1'b1;
                        r_winner <= w_winner;
                        r_fields <= w_sel_fields;
`ifdef USB3_TP_ARB_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                ARB_ISSUE: begin
                    if (bus.tp_ack) begin
                        r_done[r_winner] <= 1'b1;
                        r_tp             <= 1'b0;
                        r_state          <= ARB_IDLE;
                        r_rr_ptr         <= f_next_ptr(r_winner);
                    end else if (!w_link_up || w_timeout) begin
                        r_err[r_winner]  <= 1'b1;
                        r_tp             <= 1'b0;
                        r_state          <= ARB_IDLE;
                        r_rr_ptr         <= f_next_ptr(r_winner);
                    end
`ifdef USB3_TP_ARB_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign bus.tp         = r_tp;
    assign bus.tp_retry   = r_fields.retry;
    assign bus.tp_dir     = r_fields.dir;
    assign bus.tp_subtype = r_fields.subtype;
    assign bus.tp_endp    = r_fields.endp;
    assign bus.tp_nump    = r_fields.nump;
    assign bus.tp_seq     = r_fields.seq;
    assign bus.tp_stream  = r_fields.stream;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.busy       = (r_state == ARB_ISSUE);

endmodule

// File: tb/tb_usb3_tp_tx_arbiter.sv
// Directed self-checking bench for usb3_tp_tx_arbiter (NUM_REQ = 3).
// Inputs change and outputs are sampled on the falling clock edge.
// With USB3_TP_ARB_TIMEOUT_EN defined the timeout scenario runs with TIMEOUT_CYC = 15.
module tb_usb3_tp_tx_arbiter;
    import usb3_tp_tx_arbiter_pkg::*;

    localparam int NREQ = 3;
`ifdef USB3_TP_ARB_TIMEOUT_EN
    localparam int TO_CYC = 15;
`else
    localparam int TO_CYC = 1023;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    tp_fields_t exp_f [NREQ];

    usb3_tp_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    usb3_tp_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic tp_fields_t obs_fields();
        return {bus.tp_retry, bus.tp_dir, bus.tp_subtype, bus.tp_endp,
                bus.tp_nump, bus.tp_seq, bus.tp_stream};
    endfunction

    task automatic drive_fields();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_retry[i]            = exp_f[i].retry;
            bus.req_dir[i]              = exp_f[i].dir;
            bus.req_subtype[4*i +: 4]   = exp_f[i].subtype;
            bus.req_endp[4*i +: 4]      = exp_f[i].endp;
            bus.req_nump[5*i +: 5]      = exp_f[i].nump;
            bus.req_seq[5*i +: 5]       = exp_f[i].seq;
            bus.req_stream[16*i +: 16]  = exp_f[i].stream;
        end
    endtask

    // Granted TP owned by requester idx is on the link slot.
    task automatic check_granted(input string tag, input int idx);
        check({tag, "_tp"},     64'(bus.tp),     64'd1);
        check({tag, "_busy"},   64'(bus.busy),   64'd1);
        check({tag, "_fields"}, 64'(obs_fields()), 64'(exp_f[idx]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required end before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        exp_f[0] = '{retry: 1'b0, dir: 1'b1, subtype: 4'h1, endp: 4'h0, nump: 5'd1,  seq: 5'd7,  stream: 16'h1234};
        exp_f[1] = '{retry: 1'b1, dir: 1'b0, subtype: 4'h3, endp: 4'h5, nump: 5'd2,  seq: 5'd9,  stream: 16'hBEEF};
        exp_f[2] = '{retry: 1'b0, dir: 1'b0, subtype: 4'hA, endp: 4'hC, nump: 5'd31, seq: 5'd30, stream: 16'h0F0F};
        bus.ltssm_state = LT_U0;
        bus.req         = '0;
        bus.tp_ack      = 1'b0;
        drive_fields();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tp",     64'(bus.tp),           64'd0);
        check("rst_busy",   64'(bus.busy),         64'd0);
        check("rst_done",   64'(bus.done),         64'd0);
        check("rst_err",    64'(bus.err),          64'd0);
        check("rst_fields", 64'(obs_fields()),     64'd0);
        reset = 1'b0;

        // tp_ack in IDLE is ignored
        @(negedge clk);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("idle_ack_done", 64'(bus.done), 64'd0);
        check("idle_ack_tp",   64'(bus.tp),   64'd0);

        // Round robin with all requests held and immediate acks: 0,1,2,0
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            w = k % NREQ;
            @(negedge clk);
            check_granted("rr_grant", w);
            bus.tp_ack = 1'b1;
            @(negedge clk);
            bus.tp_ack = 1'b0;
            check("rr_done",   64'(bus.done), 64'(3'b001 << w));
            check("rr_tp_low", 64'(bus.tp),   64'd0);
        end
        bus.req = '0;

        // Single request from index 0 (pointer at 1, search wraps); late field change ignored
        @(negedge clk);
        bus.req = 3'b001;
        @(negedge clk);
        check_granted("single", 0);
        check("single_done0", 64'(bus.done), 64'd0);
        bus.req               = '0;
        bus.req_subtype[3:0]  = 4'hE;
        @(negedge clk);
        check_granted("single_latched", 0);
        @(negedge clk);
        check("single_hold_tp", 64'(bus.tp), 64'd1);
        @(negedge clk);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("single_done",  64'(bus.done), 64'b001);
        check("single_err",   64'(bus.err),  64'd0);
        check("single_tp",    64'(bus.tp),   64'd0);
        check("single_busy",  64'(bus.busy), 64'd0);
        @(negedge clk);
        check("single_done_pulse", 64'(bus.done), 64'd0);
        drive_fields();

        // Link loss in ISSUE: err to owner, pending request waits for U0
        bus.req = 3'b110;
        @(negedge clk);
        check_granted("loss_grant", 1);
        bus.ltssm_state = LT_RECOVERY;
        @(negedge clk);
        check("loss_err",  64'(bus.err),  64'b010);
        check("loss_done", 64'(bus.done), 64'd0);
        check("loss_tp",   64'(bus.tp),   64'd0);
        check("loss_busy", 64'(bus.busy), 64'd0);
        bus.req = 3'b100;
        repeat (3) begin
            @(negedge clk);
            check("loss_no_grant", 64'(bus.tp), 64'd0);
        end
        check("loss_err_pulse", 64'(bus.err), 64'd0);
        bus.ltssm_state = LT_U0;
        @(negedge clk);
        check_granted("loss_regrant", 2);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("loss_regrant_done", 64'(bus.done), 64'b100);
        bus.req = '0;

        // tp_ack and link loss in the same cycle: ack wins
        bus.req = 3'b001;
        @(negedge clk);
        check_granted("tie_grant", 0);
        bus.tp_ack      = 1'b1;
        bus.ltssm_state = LT_RECOVERY;
        @(negedge clk);
        bus.tp_ack      = 1'b0;
        bus.ltssm_state = LT_U0;
        check("tie_done", 64'(bus.done), 64'b001);
        check("tie_err",  64'(bus.err),  64'd0);
        bus.req = '0;

        // No ack: timeout abort when enabled, otherwise an indefinite hold
        bus.req = 3'b011;
        @(negedge clk);
        check_granted("to_grant", 1);
`ifdef USB3_TP_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("to_wait_tp",  64'(bus.tp),  64'd1);
            check("to_wait_err", 64'(bus.err), 64'd0);
        end
        @(negedge clk);
        check("to_err", 64'(bus.err), 64'b010);
        check("to_tp",  64'(bus.tp),  64'd0);
        bus.req = 3'b001;
        @(negedge clk);
        check_granted("to_next", 0);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("to_next_done", 64'(bus.done), 64'b001);
`else
        repeat (20) @(negedge clk);
        check("hold_tp",  64'(bus.tp),  64'd1);
        check("hold_err", 64'(bus.err), 64'd0);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("hold_done", 64'(bus.done), 64'b010);
`endif
        bus.req = '0;

        // Asynchronous reset while tp is high; first grant afterwards goes to index 0
        @(negedge clk);
        bus.req = 3'b010;
        @(negedge clk);
        check_granted("arst_grant", 1);
        #2 reset = 1'b1;
        #1;
        check("arst_tp",     64'(bus.tp),       64'd0);
        check("arst_busy",   64'(bus.busy),     64'd0);
        check("arst_fields", 64'(obs_fields()), 64'd0);
        check("arst_done",   64'(bus.done),     64'd0);
        check("arst_err",    64'(bus.err),      64'd0);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 3'b111;
        @(negedge clk);
        check_granted("arst_first", 0);
        bus.tp_ack = 1'b1;
        @(negedge clk);
        bus.tp_ack = 1'b0;
        check("arst_first_done", 64'(bus.done), 64'b001);
        bus.req = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
